fc_matmul_stream: RTL and testbench
===================================

# fc_matmul_stream

Parametrised streaming fully-connected layer engine that computes Y = W·X + B for an N×N signed weight tile W and an N×N signed activation tile X, plus a per-column bias vector B. It is the configurable, handshaked successor to the fixed 4×4 `accelerate_matrix`. Operands are streamed in row by row, a k-serial MAC array computes the result, and saturated output rows are drained under back-pressure. It sits between the operand buffers and the activation/write-back stage of the accelerator.

## Interface
- `N`, 4: matrix dimension, i.e. rows, columns and beats per tile; must be ≥ 2.
- `DW`, 8: operand and bias element width, signed two's complement.
- `OW`, 16: output element width, signed, saturated.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: engine accepts a beat. High only in LOAD.
- `w_row` in N*DW: row r of W; element k is at bits [k*DW +: DW].
- `x_row` in N*DW: row r of X; same packing as `w_row`.
- `bias` in N*DW: B[j] packed the same way; sampled on beat 0 only.
- `out_valid` out 1: output row valid.
- `out_ready` in 1: downstream accepts the row.
- `out_row` out N*OW: row i of Y; element j is at bits [j*OW +: OW].
- `out_last` out 1: marks row N−1 of the tile.
- `busy` out 1: state is not LOAD, or at least one beat of the current tile has been accepted.

## Operation
- FSM states: LOAD, COMPUTE, DRAIN.
- **LOAD:**
  - `in_ready`=1. Each beat with `in_valid` stores W row and X row at index `beat_cnt`. Beat 0 also latches `bias`.
  - On beat N−1, the accumulators clear and the FSM goes to COMPUTE.
- **COMPUTE:** runs N cycles, k = 0..N−1.
  - Every cycle, for all i, j: acc[i][j] += W[i][k]·X[k][j].
  - This needs N² multipliers. Each accumulator is AW = 2·DW + clog2(N) + 1 bits, so no internal overflow.
  - On k = N−1 the FSM goes to DRAIN with row index 0.
- **DRAIN:**
  - Each output element is sat(acc[i][j] + B[j]), where B is sign-extended to AW.
  - sat clamps to [−2^(OW−1), 2^(OW−1)−1].
  - Row i is presented with `out_valid`=1. The row index advances only on `out_valid && out_ready`.
  - The handshake on row N−1 has `out_last`=1. It returns the FSM to LOAD, and `in_ready` is 1 in the next cycle.
- Back-pressure: while `out_valid && !out_ready`, `out_row` and `out_last` stay stable.
- `in_valid` outside LOAD is ignored; no beat is consumed.
- Reset mid-operation, in any state:
  - The partial tile is discarded.
  - Beat and row counters go to 0 and the FSM returns to LOAD.
  - No output row of the aborted tile is emitted afterwards.

## Timing
- Reset values (in the cycle `rst` is sampled high and the cycle after): `in_ready`=0, `out_valid`=0, `out_last`=0, `out_row`=0, `busy`=0. `in_ready` goes to 1 the first cycle after `rst` is sampled low.
- Load: N accepted beats; gaps in `in_valid` are allowed.
- Latency:
  - First `out_valid` appears N+1 cycles after the edge that accepts beat N−1.
  - With no stalls, row i is valid at cycle N+1+i.
- Throughput with no stalls: one tile per 3N+1 cycles. There is no overlap of LOAD with DRAIN.
- Outputs are registered. There is no combinational path from `out_ready` to `out_row`. `in_ready` depends on the registered state only.

## Configuration
- `FC_RELU_EN`:
  - Defined: after saturation, negative elements are output as 0, i.e. y = max(0, sat(·)).
  - Undefined: the signed saturated value is output unchanged.
  - The macro adds no ports and does not change latency.

## Structure
- Package `fc_pkg` holds:
  - the state enum `fc_state_t` (LOAD, COMPUTE, DRAIN);
  - the accumulator-width function `fc_acc_w(DW, N)`;
  - the saturation/ReLU function `fc_sat(acc, bias, OW)`;
  - the default parameter constants.
- Sub-module `fc_mac_cell` is one signed multiply-accumulate with synchronous clear and enable. It is instantiated N² times in a generate loop.
- The top level holds the FSM, counters, the W/X/B storage registers and the drain mux.

## Test plan
All scenarios use N=4, DW=8, OW=16 unless stated.
- **Identity:** W[i][k]=4i+k, X=I, B=0 → rows {0,1,2,3}, {4,5,6,7}, {8,9,10,11}, {12,13,14,15}. `out_last` is high on row 3 only. First `out_valid` is 5 cycles after beat 3.
- **Bias and general product:** W[i][k]=4i+k, X all 1, B={1,2,3,4} → row 0 = {7,8,9,10}, row 3 = {55,56,57,58}.
- **Saturation:** W all 127, X all 127, B all 127 → every element 0x7FFF. Repeat with W all −128, B all 0 → 0x8000, or 0x0000 when `FC_RELU_EN` is defined.
- **Back-pressure and gaps:**
  - Stimulus: hold `out_ready`=0 for 3 cycles on row 1, and toggle `in_valid` every other cycle during LOAD.
  - Required: identical row data; `out_row` is stable while stalled; `in_ready`=0 throughout DRAIN.
- **Reset mid-operation:** assert `rst` after beat 1, and again in a separate run during DRAIN row 2 → no further `out_valid`. A following full identity tile produces correct results.
- **Back-to-back tiles and N=8:** two consecutive tiles give independent correct results, with `in_ready` rising the cycle after the last row handshake. Repeat the identity test with N=8.

Source files
------------

// File: rtl/fc_matmul_stream_pkg.sv
// rtl/fc_matmul_stream_pkg.sv - shared types, widths and saturation for fc_matmul_stream (FC_RELU_EN selects ReLU clamp)
package fc_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN
    } fc_state_t;

    localparam int FC_N  = 4;
    localparam int FC_DW = 8;
    localparam int FC_OW = 16;

    // Wide enough that N products of two DW-bit operands never wrap.
    function automatic int fc_acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    function automatic logic signed [63:0] fc_sat(input logic signed [63:0] acc,
                                                  input logic signed [63:0] bias,
                                                  input int ow);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] y;
        sum = acc + bias;
        hi  = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi)
            y = hi;
        else if (sum < lo)
            y = lo;
        else
            y = sum;
`ifdef FC_RELU_EN
        if (y < 64'sd0)
            y = '0;
`endif
        return y;
    endfunction

endpackage

// File: rtl/fc_matmul_stream_if.sv
// rtl/fc_matmul_stream_if.sv - operand load and result drain handshake bundle
interface fc_matmul_stream_if
    import fc_pkg::*;
#(
    parameter int N  = FC_N,
    parameter int DW = FC_DW,
    parameter int OW = FC_OW
);
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   w_row;
    logic [N*DW-1:0]   x_row;
    logic [N*DW-1:0]   bias;
    logic              out_valid;
    logic              out_ready;
    logic [N*OW-1:0]   out_row;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid, w_row, x_row, bias, out_ready,
        input  in_ready, out_valid, out_row, out_last, busy
    );

    modport slave (
        input  in_valid, w_row, x_row, bias, out_ready,
        output in_ready, out_valid, out_row, out_last, busy
    );
endinterface

// File: rtl/fc_matmul_stream_mac.sv
// rtl/fc_matmul_stream_mac.sv - fc_mac_cell: one signed multiply-accumulate with synchronous clear
module fc_mac_cell #(
    parameter int DW = 8,
    parameter int AW = 19
) (
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [AW-1:0] acc_o
);
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc_q;

    assign prod  = a_i * b_i;
    assign acc_o = acc_q;

    always_ff @(posedge clk) begin
        if (clr_i)
            acc_q <= '0;
        else if (en_i)
            acc_q <= acc_q + AW'(prod);
    end
endmodule

// File: rtl/fc_matmul_stream.sv
// rtl/fc_matmul_stream.sv - streaming Y = W*X + B engine: load N beats, k-serial MAC array, drain rows
module fc_matmul_stream
    import fc_pkg::*;
#(
    parameter int N  = FC_N,
    parameter int DW = FC_DW,
    parameter int OW = FC_OW
) (
    input  logic                clk,
    input  logic                rst,
    fc_matmul_stream_if.slave   s
);
    localparam int AW = fc_acc_w(DW, N);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    fc_state_t            state_q;
    logic [CW-1:0]        beat_q, k_q, row_q, drain_idx;
    logic                 in_ready_q, out_valid_q, out_last_q;
    logic [N*OW-1:0]      out_row_q, drain_row;
    logic signed [DW-1:0] w_q [N][N];
    logic signed [DW-1:0] x_q [N][N];
    logic signed [DW-1:0] b_q [N];
    logic signed [AW-1:0] acc_w [N][N];
    logic                 accept, mac_clr, mac_en;

    assign accept  = s.in_valid && in_ready_q;
    assign mac_clr = rst || (accept && beat_q == CW'(N - 1));
    assign mac_en  = (state_q == ST_COMPUTE);

    // Preload the next row on a handshake so consecutive rows leave without a bubble.
    assign drain_idx = out_valid_q ? row_q + CW'(1) : row_q;

    for (genvar i = 0; i < N; i++) begin : gen_row
        for (genvar j = 0; j < N; j++) begin : gen_col
            fc_mac_cell #(.DW(DW), .AW(AW)) u_mac (
                .clk   (clk),
                .clr_i (mac_clr),
                .en_i  (mac_en),
                .a_i   (w_q[i][k_q]),
                .b_i   (x_q[k_q][j]),
                .acc_o (acc_w[i][j])
            );
        end
    end

    for (genvar j = 0; j < N; j++) begin : gen_out
        assign drain_row[j*OW +: OW] = OW'(fc_sat(64'(acc_w[drain_idx][j]), 64'(b_q[j]), OW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            beat_q      <= '0;
            k_q         <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        for (int k = 0; k < N; k++) begin
                            w_q[beat_q][k] <= s.w_row[k*DW +: DW];
                            x_q[beat_q][k] <= s.x_row[k*DW +: DW];
                            if (beat_q == '0)
                                b_q[k] <= s.bias[k*DW +: DW];
                        end
                        if (beat_q == CW'(N - 1)) begin
                            beat_q     <= '0;
                            k_q        <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= ST_COMPUTE;
                        end else begin
                            beat_q <= beat_q + CW'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (k_q == CW'(N - 1)) begin
                        k_q     <= '0;
                        row_q   <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        k_q <= k_q + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_row_q   <= drain_row;
                        out_last_q  <= (row_q == CW'(N - 1));
                    end else if (s.out_ready) begin
                        if (row_q == CW'(N - 1)) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            row_q       <= '0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_LOAD;
                        end else begin
                            row_q      <= row_q + CW'(1);
                            out_row_q  <= drain_row;
                            out_last_q <= (drain_idx == CW'(N - 1));
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_row   = out_row_q;
    assign s.out_last  = out_last_q;
    assign s.busy      = (state_q != ST_LOAD) || (beat_q != '0);
endmodule

// File: tb/tb_fc_matmul_stream.sv
// tb/tb_fc_matmul_stream.sv - directed self-checking bench for fc_matmul_stream at N=4 and N=8
module tb_fc_matmul_stream;
    typedef int mat4_t [4][4];
    typedef int vec4_t [4];
    typedef logic [63:0] rows4_t [4];

    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst8 = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_matmul_stream_if #(.N(4), .DW(8), .OW(16)) bus4 ();
    fc_matmul_stream_if #(.N(8), .DW(8), .OW(16)) bus8 ();

    fc_matmul_stream #(.N(4), .DW(8), .OW(16)) dut4 (.clk(clk), .rst(rst4), .s(bus4.slave));
    fc_matmul_stream #(.N(8), .DW(8), .OW(16)) dut8 (.clk(clk), .rst(rst8), .s(bus8.slave));

    mat4_t  wa, xa;
    vec4_t  ba;
    rows4_t rows;
    logic [3:0] lasts;
    int     c0, fc;
    bit     stable_ok, ready_low_ok, ready_after;

    function automatic logic [63:0] pk4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic set_ramp_identity();
        for (int i = 0; i < 4; i++) begin
            ba[i] = 0;
            for (int k = 0; k < 4; k++) begin
                wa[i][k] = 4 * i + k;
                xa[i][k] = (i == k) ? 1 : 0;
            end
        end
    endtask

    task automatic set_ramp_ones();
        for (int i = 0; i < 4; i++) begin
            ba[i] = i + 1;
            for (int k = 0; k < 4; k++) begin
                wa[i][k] = 4 * i + k;
                xa[i][k] = 1;
            end
        end
    endtask

    task automatic load4(input mat4_t w, input mat4_t x, input vec4_t b, input bit gaps,
                         input int nbeats, output int acc_cyc);
        int beat = 0;
        int t = 0;
        bit tog = 1'b0;
        acc_cyc = -1;
        while (beat < nbeats && t < 200) begin
            @(negedge clk);
            t++;
            tog = gaps ? !tog : 1'b1;
            bus4.in_valid = tog;
            for (int k = 0; k < 4; k++) begin
                bus4.w_row[k*8 +: 8] = 8'(w[beat][k]);
                bus4.x_row[k*8 +: 8] = 8'(x[beat][k]);
                bus4.bias[k*8 +: 8]  = 8'(b[k]);
            end
            if (tog && bus4.in_ready) begin
                if (beat == 3) acc_cyc = cyc + 1;
                beat++;
            end
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        if (beat < nbeats) begin
            checks++; errors++;
            $display("FAIL load_timeout: beats accepted %0d required %0d", beat, nbeats);
        end
    endtask

    task automatic drain4(input int stall_row, input int stall_n, output rows4_t r_out,
                          output logic [3:0] l_out, output int first_cyc, output bit st_ok,
                          output bit rl_ok, output bit r_after);
        int r = 0;
        int t = 0;
        int st = 0;
        logic [64:0] held = '0;
        st_ok = 1'b1; rl_ok = 1'b1; first_cyc = -1; l_out = '0; r_after = 1'b0;
        for (int i = 0; i < 4; i++) r_out[i] = '0;
        bus4.out_ready = 1'b1;
        while (r < 4 && t < 300) begin
            @(negedge clk);
            t++;
            if (bus4.in_ready) rl_ok = 1'b0;
            if (bus4.out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (r == stall_row && st < stall_n) begin
                    if (st == 0) held = {bus4.out_last, bus4.out_row};
                    else if ({bus4.out_last, bus4.out_row} !== held) st_ok = 1'b0;
                    st++;
                    bus4.out_ready = 1'b0;
                end else begin
                    if (st > 0 && r == stall_row && {bus4.out_last, bus4.out_row} !== held) st_ok = 1'b0;
                    r_out[r] = bus4.out_row;
                    l_out[r] = bus4.out_last;
                    r++;
                    bus4.out_ready = 1'b1;
                end
            end
        end
        if (r < 4) begin
            checks++; errors++;
            $display("FAIL drain_timeout: rows seen %0d required 4", r);
        end
        @(negedge clk);
        r_after = bus4.in_ready;
    endtask

    task automatic test_reset();
        rst4 = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus4.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus4.in_ready); end
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus4.out_valid); end
        checks++; if (bus4.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b expected 0", bus4.out_last); end
        checks++; if (bus4.out_row !== 64'h0) begin errors++; $display("FAIL rst_out_row: got %h expected 0", bus4.out_row); end
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus4.busy); end
        rst4 = 1'b0;
        @(negedge clk);
        checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus4.in_ready); end
    endtask

    task automatic test_identity();
        set_ramp_identity();
        load4(wa, xa, ba, 1'b0, 4, c0);
        drain4(-1, 0, rows, lasts, fc, stable_ok, ready_low_ok, ready_after);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rows[i] !== pk4(4*i, 4*i+1, 4*i+2, 4*i+3)) begin
                errors++; $display("FAIL identity_row%0d: got %h expected %h", i, rows[i], pk4(4*i, 4*i+1, 4*i+2, 4*i+3));
            end
        end
        checks++; if (lasts !== 4'b1000) begin errors++; $display("FAIL identity_last: got %b expected 1000", lasts); end
        checks++; if (fc - c0 !== 5) begin errors++; $display("FAIL identity_latency: got %0d expected 5", fc - c0); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL identity_ready_after: got %b expected 1", ready_after); end
    endtask

    task automatic test_bias();
        set_ramp_ones();
        load4(wa, xa, ba, 1'b0, 4, c0);
        drain4(-1, 0, rows, lasts, fc, stable_ok, ready_low_ok, ready_after);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rows[i] !== pk4(16*i+7, 16*i+8, 16*i+9, 16*i+10)) begin
                errors++; $display("FAIL bias_row%0d: got %h expected %h", i, rows[i], pk4(16*i+7, 16*i+8, 16*i+9, 16*i+10));
            end
        end
    endtask

    task automatic test_saturation();
        logic [63:0] neg_exp;
`ifdef FC_RELU_EN
        neg_exp = 64'h0;
`else
        neg_exp = 64'h8000_8000_8000_8000;
`endif
        for (int i = 0; i < 4; i++) begin
            ba[i] = 127;
            for (int k = 0; k < 4; k++) begin wa[i][k] = 127; xa[i][k] = 127; end
        end
        load4(wa, xa, ba, 1'b0, 4, c0);
        drain4(-1, 0, rows, lasts, fc, stable_ok, ready_low_ok, ready_after);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rows[i] !== 64'h7fff_7fff_7fff_7fff) begin errors++; $display("FAIL sat_pos_row%0d: got %h expected 7fff7fff7fff7fff", i, rows[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            ba[i] = 0;
            for (int k = 0; k < 4; k++) wa[i][k] = -128;
        end
        load4(wa, xa, ba, 1'b0, 4, c0);
        drain4(-1, 0, rows, lasts, fc, stable_ok, ready_low_ok, ready_after);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rows[i] !== neg_exp) begin errors++; $display("FAIL sat_neg_row%0d: got %h expected %h", i, rows[i], neg_exp); end
        end
    endtask

    task automatic test_backpressure();
        set_ramp_identity();
        load4(wa, xa, ba, 1'b1, 4, c0);
        drain4(1, 3, rows, lasts, fc, stable_ok, ready_low_ok, ready_after);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rows[i] !== pk4(4*i, 4*i+1, 4*i+2, 4*i+3)) begin
                errors++; $display("FAIL bp_row%0d: got %h expected %h", i, rows[i], pk4(4*i, 4*i+1, 4*i+2, 4*i+3));
            end
        end
        checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b expected 1", stable_ok); end
        checks++; if (ready_low_ok !== 1'b1) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 1", ready_low_ok); end
        checks++; if (lasts !== 4'b1000) begin errors++; $display("FAIL bp_last: got %b expected 1000", lasts); end
    endtask

    task automatic test_reset_mid();
        int seen;
        int hs;
        int t;
        set_ramp_identity();
        load4(wa, xa, ba, 1'b0, 2, c0);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL midrst_load_busy: got %b expected 0", bus4.busy); end
        seen = 0;
        repeat (20) begin @(negedge clk); if (bus4.out_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_load_no_out: got %0d valid cycles expected 0", seen); end
        load4(wa, xa, ba, 1'b0, 4, c0);
        bus4.out_ready = 1'b1;
        hs = 0; t = 0;
        while (t < 100) begin
            @(negedge clk);
            t++;
            if (bus4.out_valid) begin
                if (hs == 2) break;
                hs++;
            end
        end
        checks++; if (hs !== 2) begin errors++; $display("FAIL midrst_drain_reach: got %0d rows expected 2", hs); end
        rst4 = 1'b1;
        bus4.out_ready = 1'b0;
        @(negedge clk);
        rst4 = 1'b0;
        seen = 0;
        repeat (20) begin if (bus4.out_valid) seen++; @(negedge clk); end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_drain_no_out: got %0d valid cycles expected 0", seen); end
        load4(wa, xa, ba, 1'b0, 4, c0);
        drain4(-1, 0, rows, lasts, fc, stable_ok, ready_low_ok, ready_after);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rows[i] !== pk4(4*i, 4*i+1, 4*i+2, 4*i+3)) begin
                errors++; $display("FAIL midrst_after_row%0d: got %h expected %h", i, rows[i], pk4(4*i, 4*i+1, 4*i+2, 4*i+3));
            end
        end
    endtask

    task automatic test_back_to_back();
        set_ramp_identity();
        load4(wa, xa, ba, 1'b0, 4, c0);
        drain4(-1, 0, rows, lasts, fc, stable_ok, ready_low_ok, ready_after);
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: got %b expected 1", ready_after); end
        checks++; if (rows[3] !== pk4(12, 13, 14, 15)) begin errors++; $display("FAIL b2b_a_row3: got %h expected %h", rows[3], pk4(12, 13, 14, 15)); end
        set_ramp_ones();
        load4(wa, xa, ba, 1'b0, 4, c0);
        drain4(-1, 0, rows, lasts, fc, stable_ok, ready_low_ok, ready_after);
        checks++; if (rows[0] !== pk4(7, 8, 9, 10)) begin errors++; $display("FAIL b2b_b_row0: got %h expected %h", rows[0], pk4(7, 8, 9, 10)); end
        checks++; if (rows[3] !== pk4(55, 56, 57, 58)) begin errors++; $display("FAIL b2b_b_row3: got %h expected %h", rows[3], pk4(55, 56, 57, 58)); end
    endtask

    task automatic test_n8();
        logic [127:0] exp_row;
        logic [127:0] rows8 [8];
        logic [7:0]   last8;
        int beat, t, r, a0, f0;
        rst8 = 1'b0;
        @(negedge clk);
        beat = 0; t = 0; a0 = -1; f0 = -1; last8 = '0;
        while (beat < 8 && t < 200) begin
            @(negedge clk);
            t++;
            bus8.in_valid = 1'b1;
            for (int k = 0; k < 8; k++) begin
                bus8.w_row[k*8 +: 8] = 8'(8 * beat + k);
                bus8.x_row[k*8 +: 8] = (k == beat) ? 8'd1 : 8'd0;
                bus8.bias[k*8 +: 8]  = 8'd0;
            end
            if (bus8.in_ready) begin
                if (beat == 7) a0 = cyc + 1;
                beat++;
            end
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        r = 0; t = 0;
        while (r < 8 && t < 300) begin
            @(negedge clk);
            t++;
            if (bus8.out_valid) begin
                if (f0 < 0) f0 = cyc;
                rows8[r] = bus8.out_row;
                last8[r] = bus8.out_last;
                r++;
            end
        end
        checks++; if (r !== 8) begin errors++; $display("FAIL n8_rows_seen: got %0d expected 8", r); end
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < 8; j++) exp_row[j*16 +: 16] = 16'(8 * i + j);
            checks++; if (rows8[i] !== exp_row) begin errors++; $display("FAIL n8_row%0d: got %h expected %h", i, rows8[i], exp_row); end
        end
        checks++; if (last8 !== 8'h80) begin errors++; $display("FAIL n8_last: got %b expected 10000000", last8); end
        checks++; if (f0 - a0 !== 9) begin errors++; $display("FAIL n8_latency: got %0d expected 9", f0 - a0); end
    endtask

    initial begin
        bus4.in_valid = 1'b0; bus4.w_row = '0; bus4.x_row = '0; bus4.bias = '0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.w_row = '0; bus8.x_row = '0; bus8.bias = '0; bus8.out_ready = 1'b1;
        test_reset();
        test_identity();
        test_bias();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_n8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
